dm_cache_ctrl: RTL and testbench
================================

// Module: dm_cache_ctrl
// PURPOSE
// Parametrised direct-mapped, write-through cache controller; successor to the 8-bit/8-line controller.
// Sits between the CPU request port and the bus arbitrator, holds its own tag/valid/data arrays
// and invalidates lines on bus snoops. Adds a parametrised geometry, a selectable write-allocate policy,
// a done strobe, snoop_hit reporting and saturating hit/miss counters.
// PARAMETERS
// ADDR_W          8   address width; TAG_W = ADDR_W-INDEX_W, must be >= 1
// DATA_W          8   data word width (one word per line)
// INDEX_W         3   log2(number of lines); LINES = 2**INDEX_W
// WRITE_ALLOCATE  1   1: a write miss installs tag+data; 0: a write miss leaves the arrays unchanged
// CNT_W           16  width of the hit/miss statistics counters
// PORTS
// CC_clk           in   1        clock
// rst              in   1        reset
// start            in   1        request strobe; sampled only when cache_busy=0
// read_operation   in   1        1=read, 0=write (sampled with start)
// address          in   ADDR_W   request address {tag,index}
// write_data       in   DATA_W   write data (sampled with start)
// read_data        out  DATA_W   read result; valid when done=1, then held until the next read completes
// done             out  1        one-cycle pulse: request complete
// hit / miss       out  1        lookup result of the last accepted request, held; miss = ~hit
// cache_busy       out  1        1 from acceptance to completion; start is ignored while it is 1
// bus_access       out  1        bus request; held until finish
// write_opn_to_bus out  1        bus op: 1=write, 0=read; valid while bus_access=1
// bus_addr         out  ADDR_W   bus address (latched request address)
// bus_wdata        out  DATA_W   bus write data
// bus_rdata        in   DATA_W   bus read data; valid when finish=1
// finish           in   1        bus arbitrator completion, one cycle
// flag_snoop       in   1        snoop valid
// snoop_address    in   ADDR_W   snooped write address
// snoop_hit        out  1        registered; 1 the cycle after a snoop invalidated a valid line
// hit_count        out  CNT_W    accepted requests that hit; saturates at all-ones
// miss_count       out  CNT_W    accepted requests that missed; saturates at all-ones
// BEHAVIOUR
// - Reset: rst, synchronous, active-high; clock CC_clk. All outputs 0, all valid bits 0,
//   state=IDLE, counters 0. Reset mid-transaction aborts it: bus_access drops the next edge and no array write occurs.
// - Lookup is combinational from the registered arrays: hit = valid[idx] && tag[idx]==address tag.
// - FSM IDLE / RD_MISS / WR_BUS.
//   IDLE, start=1, read hit:  read_data<=data[idx], done=1 next cycle, stay IDLE. Latency 1; cache_busy stays 0.
//   IDLE, start=1, read miss: latch address; cache_busy=1, bus_access=1, write_opn_to_bus=0 -> RD_MISS.
//   RD_MISS on finish: read_data<=bus_rdata, line<=data, tag<=latched tag, valid<=1 (unless poisoned),
//     done=1, cache_busy=0, bus_access=0 -> IDLE.
//   IDLE, start=1, write: latch address/data; bus_access=1, write_opn_to_bus=1, cache_busy=1 -> WR_BUS.
//     On a hit, or on a miss with WRITE_ALLOCATE=1, the line is written at acceptance (data, tag, valid=1).
//   WR_BUS on finish: done=1, cache_busy=0, bus_access=0 -> IDLE.
// - Snoop (any state): if flag_snoop and valid[sidx] and tag matches: valid[sidx]<=0, snoop_hit=1 next cycle.
// - Priorities in the same cycle:
//   snoop and lookup on the same line: the lookup sees the post-invalidate state (miss).
//   snoop and an allocating write on the same line: the snoop wins and the line ends invalid.
//   snoop matching the latched address during RD_MISS: set poison; the fill still returns read_data
//     but leaves valid=0. Poison clears on return to IDLE.
// - finish while IDLE is ignored. start while busy is ignored and not counted.
// - Counters increment once per accepted request and saturate without wrap.
// STRUCTURE
// - Package cc_pkg: state enum (IDLE=0, RD_MISS=1, WR_BUS=2), localparam helpers TAG_W and LINES.
// - One sub-module, cc_line_array: tag/valid/data register file. Async read port; one sync write port;
//   separate valid-clear port for snoop, with clear winning over write.
// TESTING
// 1 Reset, then read 0x2A -> miss, bus_access=1, write_opn_to_bus=0, bus_addr=0x2A; finish with bus_rdata=0x5C
//   -> done, read_data=0x5C, miss_count=1.
// 2 Read 0x2A again -> hit, done 1 cycle later, read_data=0x5C, no bus_access, hit_count=1.
// 3 WRITE_ALLOCATE=1: write 0x91<=0x77 (miss) -> bus write 0x91/0x77; then read 0x91 hits with 0x77.
//   Repeat with WRITE_ALLOCATE=0: the read misses.
// 4 flag_snoop with snoop_address=0x2A after test 2 -> snoop_hit=1; read 0x2A now misses.
//   Snoop 0x32 (same index, different tag) -> no invalidate.
// 5 Read miss 0x10; snoop 0x10 during RD_MISS; finish 0xAB -> read_data=0xAB; next read 0x10 misses (poison).
// 6 rst asserted in RD_MISS -> bus_access=0 next edge; read 0x10 misses; INDEX_W=4, ADDR_W=10 regression; counter saturation at CNT_W=2.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared types and geometry helpers for the direct-mapped cache controller.
package cc_pkg;

    // Controller FSM encoding; values are visible on the debug state output.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_BUS  = 2'd2
    } cc_state_e;

    // Tag width left over once the index bits are taken from the address.
    function automatic int cc_tag_w(input int addr_w, input int index_w);
        return addr_w - index_w;
    endfunction

    // Number of lines held by the array.
    function automatic int cc_lines(input int index_w);
        return 1 << index_w;
    endfunction

endpackage

// File: rtl/cc_line_array.sv
// Tag/valid/data register file for the direct-mapped cache.
// Two async read ports (lookup and snoop), one sync write port, and a
// valid-clear port for snoop invalidation that overrides a same-line write.
module cc_line_array
    import cc_pkg::*;
#(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 8
) (
    input  logic              CC_clk,
    input  logic              rst,
    // lookup read port
    input  logic [INDEX_W-1:0] i_rd_idx,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic               o_rd_valid,
    output logic [DATA_W-1:0]  o_rd_data,
    // snoop read port
    input  logic [INDEX_W-1:0] i_snp_idx,
    output logic [TAG_W-1:0]   o_snp_tag,
    output logic               o_snp_valid,
    // write port
    input  logic               i_we,
    input  logic [INDEX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [DATA_W-1:0]  i_wr_data,
    input  logic               i_wr_valid,
    // valid-clear port
    input  logic               i_clr,
    input  logic [INDEX_W-1:0] i_clr_idx
);

    localparam int LINES = cc_lines(INDEX_W);

    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];
    logic [LINES-1:0]  r_valid;

    assign o_rd_tag    = r_tag[i_rd_idx];
    assign o_rd_valid  = r_valid[i_rd_idx];
    assign o_rd_data   = r_data[i_rd_idx];
    assign o_snp_tag   = r_tag[i_snp_idx];
    assign o_snp_valid = r_valid[i_snp_idx];

    // Array update: write first, clear last so an invalidate wins on the same line.
    always_ff @(posedge CC_clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < LINES; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (i_we) begin
                r_tag[i_wr_idx]   <= i_wr_tag;
                r_data[i_wr_idx]  <= i_wr_data;
                r_valid[i_wr_idx] <= i_wr_valid;
            end
            if (i_clr) begin
                r_valid[i_clr_idx] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through cache controller with snoop invalidation,
// selectable write-allocate, and saturating hit/miss counters.
//
// Handshake: a request is accepted on the cycle start=1 while cache_busy=0.
// Read hits complete the next cycle (done pulse, no bus use). Everything else
// raises bus_access until the arbitrator pulses finish, then pulses done.
module dm_cache_ctrl
    import cc_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int INDEX_W        = 3,
    parameter bit WRITE_ALLOCATE = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic              CC_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              read_operation,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              done,
    output logic              hit,
    output logic              miss,
    output logic              cache_busy,
    output logic              bus_access,
    output logic              write_opn_to_bus,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              finish,
    input  logic              flag_snoop,
    input  logic [ADDR_W-1:0] snoop_address,
    output logic              snoop_hit,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic [1:0]        o_dbg_state
);

    localparam int TAG_W = cc_tag_w(ADDR_W, INDEX_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    cc_state_e         r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_read_data;
    logic              r_done;
    logic              r_hit;
    logic              r_miss;
    logic              r_busy;
    logic              r_bus_access;
    logic              r_wr_op;
    logic              r_poison;
    logic              r_snoop_hit;
    logic [CNT_W-1:0]  r_hit_count;
    logic [CNT_W-1:0]  r_miss_count;

    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_sidx;
    logic [TAG_W-1:0]   w_stag;
    logic [TAG_W-1:0]   w_rd_tag;
    logic               w_rd_valid;
    logic [DATA_W-1:0]  w_rd_data;
    logic [TAG_W-1:0]   w_snp_tag;
    logic               w_snp_valid;
    logic               w_snoop_inv;
    logic               w_hit;
    logic               w_accept;
    logic               w_snoop_latched;
    logic               w_fill;
    logic               w_alloc;
    logic               w_we;
    logic [INDEX_W-1:0] w_wr_idx;
    logic [TAG_W-1:0]   w_wr_tag;
    logic [DATA_W-1:0]  w_wr_data;
    logic               w_wr_valid;

    assign w_idx  = address[INDEX_W-1:0];
    assign w_tag  = address[ADDR_W-1:INDEX_W];
    assign w_sidx = snoop_address[INDEX_W-1:0];
    assign w_stag = snoop_address[ADDR_W-1:INDEX_W];

    // A snoop only invalidates a line that is actually present.
    assign w_snoop_inv = flag_snoop && w_snp_valid && (w_snp_tag == w_stag);

    // The lookup sees the line as already invalidated by a same-cycle snoop.
    assign w_hit = w_rd_valid && (w_rd_tag == w_tag) &&
                   !(w_snoop_inv && (w_sidx == w_idx));

    assign w_accept = (r_state == IDLE) && start;

    // Snoop against the outstanding miss address, whether or not the line is valid.
    assign w_snoop_latched = flag_snoop && (snoop_address == r_addr);

    assign w_fill  = (r_state == RD_MISS) && finish;
    assign w_alloc = w_accept && !read_operation && (w_hit || WRITE_ALLOCATE);
    assign w_we    = !rst && (w_fill || w_alloc);

    // Fill and allocate come from different states, so they never collide.
    assign w_wr_idx   = w_fill ? r_addr[INDEX_W-1:0]      : w_idx;
    assign w_wr_tag   = w_fill ? r_addr[ADDR_W-1:INDEX_W] : w_tag;
    assign w_wr_data  = w_fill ? bus_rdata                : write_data;
    assign w_wr_valid = w_fill ? !(r_poison || w_snoop_latched) : 1'b1;

    cc_line_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_lines (
        .CC_clk      (CC_clk),
        .rst         (rst),
        .i_rd_idx    (w_idx),
        .o_rd_tag    (w_rd_tag),
        .o_rd_valid  (w_rd_valid),
        .o_rd_data   (w_rd_data),
        .i_snp_idx   (w_sidx),
        .o_snp_tag   (w_snp_tag),
        .o_snp_valid (w_snp_valid),
        .i_we        (w_we),
        .i_wr_idx    (w_wr_idx),
        .i_wr_tag    (w_wr_tag),
        .i_wr_data   (w_wr_data),
        .i_wr_valid  (w_wr_valid),
        .i_clr       (w_snoop_inv && !rst),
        .i_clr_idx   (w_sidx)
    );

    // Request FSM with registered handshake and bus outputs.
    always_ff @(posedge CC_clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_read_data  <= '0;
            r_done       <= 1'b0;
            r_hit        <= 1'b0;
            r_miss       <= 1'b0;
            r_busy       <= 1'b0;
            r_bus_access <= 1'b0;
            r_wr_op      <= 1'b0;
            r_poison     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_poison <= 1'b0;
                    if (start) begin
                        r_hit  <= w_hit;
                        r_miss <= !w_hit;
                        if (read_operation && w_hit) begin
                            r_read_data <= w_rd_data;
                            r_done      <= 1'b1;
                        end else if (read_operation) begin
                            r_addr       <= address;
                            r_busy       <= 1'b1;
                            r_bus_access <= 1'b1;
                            r_wr_op      <= 1'b0;
                            r_state      <= RD_MISS;
                        end else begin
                            r_addr       <= address;
                            r_wdata      <= write_data;
                            r_busy       <= 1'b1;
                            r_bus_access <= 1'b1;
                            r_wr_op      <= 1'b1;
                            r_state      <= WR_BUS;
                        end
                    end
                end
                RD_MISS: begin
                    if (w_snoop_latched) begin
                        r_poison <= 1'b1;
                    end
                    if (finish) begin
                        r_read_data  <= bus_rdata;
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_bus_access <= 1'b0;
                        r_poison     <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                WR_BUS: begin
                    if (finish) begin
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_bus_access <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Saturating hit/miss statistics, one step per accepted request.
    always_ff @(posedge CC_clk) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (w_accept) begin
            if (w_hit && (r_hit_count != CNT_MAX)) begin
                r_hit_count <= r_hit_count + CNT_W'(1);
            end
            if (!w_hit && (r_miss_count != CNT_MAX)) begin
                r_miss_count <= r_miss_count + CNT_W'(1);
            end
        end
    end

    // Report a snoop that removed a valid line, one cycle later.
    always_ff @(posedge CC_clk) begin
        if (rst) begin
            r_snoop_hit <= 1'b0;
        end else begin
            r_snoop_hit <= w_snoop_inv;
        end
    end

    assign read_data        = r_read_data;
    assign done             = r_done;
    assign hit              = r_hit;
    assign miss             = r_miss;
    assign cache_busy       = r_busy;
    assign bus_access       = r_bus_access;
    assign write_opn_to_bus = r_wr_op;
    assign bus_addr         = r_addr;
    assign bus_wdata        = r_wdata;
    assign snoop_hit        = r_snoop_hit;
    assign hit_count        = r_hit_count;
    assign miss_count       = r_miss_count;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: instance A uses the default geometry with write
// allocate; instance B uses a 10-bit address, 16 lines, no write allocate and
// 2-bit counters. Both share stimulus buses; sel routes start/finish/snoop.
module tb_dm_cache_ctrl;

    logic       CC_clk;
    logic       rst;
    logic       sel;
    logic       start;
    logic       read_operation;
    logic [9:0] address;
    logic [7:0] write_data;
    logic [7:0] bus_rdata;
    logic       finish;
    logic       flag_snoop;
    logic [9:0] snoop_address;

    logic [7:0]  a_read_data, b_read_data;
    logic        a_done, b_done, a_hit, b_hit, a_miss, b_miss;
    logic        a_busy, b_busy, a_bus_access, b_bus_access, a_wr_op, b_wr_op;
    logic [7:0]  a_bus_addr;
    logic [9:0]  b_bus_addr;
    logic [7:0]  a_bus_wdata, b_bus_wdata;
    logic        a_snoop_hit, b_snoop_hit;
    logic [15:0] a_hc, a_mc;
    logic [1:0]  b_hc, b_mc;
    logic [1:0]  a_state, b_state;

    int n_checks = 0;
    int n_err    = 0;

    // Clock and watchdog
    initial CC_clk = 1'b0;
    always #5 CC_clk = ~CC_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    dm_cache_ctrl #(
        .ADDR_W(8), .DATA_W(8), .INDEX_W(3), .WRITE_ALLOCATE(1'b1), .CNT_W(16)
    ) u_dut_a (
        .CC_clk(CC_clk), .rst(rst), .start(start && !sel),
        .read_operation(read_operation), .address(address[7:0]),
        .write_data(write_data), .read_data(a_read_data), .done(a_done),
        .hit(a_hit), .miss(a_miss), .cache_busy(a_busy), .bus_access(a_bus_access),
        .write_opn_to_bus(a_wr_op), .bus_addr(a_bus_addr), .bus_wdata(a_bus_wdata),
        .bus_rdata(bus_rdata), .finish(finish && !sel),
        .flag_snoop(flag_snoop && !sel), .snoop_address(snoop_address[7:0]),
        .snoop_hit(a_snoop_hit), .hit_count(a_hc), .miss_count(a_mc),
        .o_dbg_state(a_state)
    );

    dm_cache_ctrl #(
        .ADDR_W(10), .DATA_W(8), .INDEX_W(4), .WRITE_ALLOCATE(1'b0), .CNT_W(2)
    ) u_dut_b (
        .CC_clk(CC_clk), .rst(rst), .start(start && sel),
        .read_operation(read_operation), .address(address),
        .write_data(write_data), .read_data(b_read_data), .done(b_done),
        .hit(b_hit), .miss(b_miss), .cache_busy(b_busy), .bus_access(b_bus_access),
        .write_opn_to_bus(b_wr_op), .bus_addr(b_bus_addr), .bus_wdata(b_bus_wdata),
        .bus_rdata(bus_rdata), .finish(finish && sel),
        .flag_snoop(flag_snoop && sel), .snoop_address(snoop_address),
        .snoop_hit(b_snoop_hit), .hit_count(b_hc), .miss_count(b_mc),
        .o_dbg_state(b_state)
    );

    // View of the selected instance
    logic [7:0]  v_read_data, v_bus_wdata;
    logic        v_done, v_hit, v_miss, v_busy, v_bus_access, v_wr_op, v_snoop_hit;
    logic [9:0]  v_bus_addr;
    logic [15:0] v_hc, v_mc;

    assign v_read_data  = sel ? b_read_data  : a_read_data;
    assign v_bus_wdata  = sel ? b_bus_wdata  : a_bus_wdata;
    assign v_done       = sel ? b_done       : a_done;
    assign v_hit        = sel ? b_hit        : a_hit;
    assign v_miss       = sel ? b_miss       : a_miss;
    assign v_busy       = sel ? b_busy       : a_busy;
    assign v_bus_access = sel ? b_bus_access : a_bus_access;
    assign v_wr_op      = sel ? b_wr_op      : a_wr_op;
    assign v_snoop_hit  = sel ? b_snoop_hit  : a_snoop_hit;
    assign v_bus_addr   = sel ? b_bus_addr   : {2'b00, a_bus_addr};
    assign v_hc         = sel ? {14'd0, b_hc} : a_hc;
    assign v_mc         = sel ? {14'd0, b_mc} : a_mc;

    typedef struct {
        logic        is_snoop;
        logic        sel;
        logic        rd;
        logic [9:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  brdata;
        logic        exp_hit;
        logic [7:0]  exp_rdata;
        logic [15:0] exp_hc;
        logic [15:0] exp_mc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic rd, input logic [9:0] a,
                                input logic [7:0] wd, input logic [7:0] brd,
                                input logic eh, input logic [7:0] erd,
                                input logic [15:0] hc, input logic [15:0] mc);
        vec_t v;
        v.is_snoop = 1'b0; v.sel = s; v.rd = rd; v.addr = a; v.wdata = wd;
        v.brdata = brd; v.exp_hit = eh; v.exp_rdata = erd; v.exp_hc = hc; v.exp_mc = mc;
        return v;
    endfunction

    function automatic vec_t mk_snp(input logic s, input logic [9:0] a, input logic eh);
        vec_t v;
        v = mk(s, 1'b0, a, 8'h00, 8'h00, eh, 8'h00, 16'd0, 16'd0);
        v.is_snoop = 1'b1;
        return v;
    endfunction

    // Scoreboard compare
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CC_clk);
        #1;
    endtask

    // Driver: one full request including the bus phase when one is expected
    task automatic do_req(input vec_t v, input int k);
        sel = v.sel; read_operation = v.rd; address = v.addr; write_data = v.wdata;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk($sformatf("v%0d hit", k), v_hit, v.exp_hit);
        chk($sformatf("v%0d miss", k), v_miss, !v.exp_hit);
        chk($sformatf("v%0d hit_count", k), v_hc, v.exp_hc);
        chk($sformatf("v%0d miss_count", k), v_mc, v.exp_mc);
        if (v.rd && v.exp_hit) begin
            chk($sformatf("v%0d done", k), v_done, 1);
            chk($sformatf("v%0d read_data", k), v_read_data, v.exp_rdata);
            chk($sformatf("v%0d busy", k), v_busy, 0);
            chk($sformatf("v%0d bus_access", k), v_bus_access, 0);
        end else begin
            chk($sformatf("v%0d busy", k), v_busy, 1);
            chk($sformatf("v%0d bus_access", k), v_bus_access, 1);
            chk($sformatf("v%0d wr_op", k), v_wr_op, !v.rd);
            chk($sformatf("v%0d bus_addr", k), v_bus_addr, v.addr);
            if (!v.rd) chk($sformatf("v%0d bus_wdata", k), v_bus_wdata, v.wdata);
            chk($sformatf("v%0d done_early", k), v_done, 0);
            tick();
            chk($sformatf("v%0d bus_hold", k), v_bus_access, 1);
            finish = 1'b1; bus_rdata = v.brdata;
            tick();
            finish = 1'b0;
            chk($sformatf("v%0d done", k), v_done, 1);
            chk($sformatf("v%0d busy_end", k), v_busy, 0);
            chk($sformatf("v%0d bus_release", k), v_bus_access, 0);
            if (v.rd) chk($sformatf("v%0d read_data", k), v_read_data, v.exp_rdata);
        end
        tick();
        chk($sformatf("v%0d done_pulse", k), v_done, 0);
    endtask

    task automatic do_snoop(input vec_t v, input int k);
        sel = v.sel; flag_snoop = 1'b1; snoop_address = v.addr;
        tick();
        flag_snoop = 1'b0;
        chk($sformatf("v%0d snoop_hit", k), v_snoop_hit, v.exp_hit);
        tick();
        chk($sformatf("v%0d snoop_hit_clear", k), v_snoop_hit, 0);
    endtask

    initial begin
        sel = 1'b0; start = 1'b0; read_operation = 1'b0; address = '0;
        write_data = '0; bus_rdata = '0; finish = 1'b0; flag_snoop = 1'b0;
        snoop_address = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state of both instances
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk($sformatf("rst%0d outs", s),
                {v_done, v_hit, v_miss, v_busy, v_bus_access, v_wr_op, v_snoop_hit}, 0);
            chk($sformatf("rst%0d read_data", s), v_read_data, 0);
            chk($sformatf("rst%0d bus_addr", s), v_bus_addr, 0);
            chk($sformatf("rst%0d counts", s), {v_hc, v_mc}, 0);
        end

        // Instance A: default geometry, write allocate
        vecs.push_back(mk(0, 1, 10'h02A, 8'h00, 8'h5C, 0, 8'h5C, 0, 1));
        vecs.push_back(mk(0, 1, 10'h02A, 8'h00, 8'h00, 1, 8'h5C, 1, 1));
        vecs.push_back(mk(0, 0, 10'h091, 8'h77, 8'h00, 0, 8'h00, 1, 2));
        vecs.push_back(mk(0, 1, 10'h091, 8'h00, 8'h00, 1, 8'h77, 2, 2));
        vecs.push_back(mk_snp(0, 10'h032, 0));
        vecs.push_back(mk_snp(0, 10'h02A, 1));
        vecs.push_back(mk(0, 1, 10'h02A, 8'h00, 8'h11, 0, 8'h11, 2, 3));
        vecs.push_back(mk(0, 0, 10'h02A, 8'h22, 8'h00, 1, 8'h00, 3, 3));
        vecs.push_back(mk(0, 1, 10'h02A, 8'h00, 8'h00, 1, 8'h22, 4, 3));
        vecs.push_back(mk(0, 1, 10'h055, 8'h00, 8'h40, 0, 8'h40, 4, 4));
        // Instance B: wide address, no write allocate, 2-bit counters
        vecs.push_back(mk(1, 0, 10'h291, 8'h77, 8'h00, 0, 8'h00, 0, 1));
        vecs.push_back(mk(1, 1, 10'h291, 8'h00, 8'h66, 0, 8'h66, 0, 2));
        vecs.push_back(mk(1, 1, 10'h291, 8'h00, 8'h00, 1, 8'h66, 1, 2));
        vecs.push_back(mk(1, 1, 10'h091, 8'h00, 8'h33, 0, 8'h33, 1, 3));
        vecs.push_back(mk(1, 1, 10'h291, 8'h00, 8'h66, 0, 8'h66, 1, 3));
        vecs.push_back(mk(1, 1, 10'h291, 8'h00, 8'h00, 1, 8'h66, 2, 3));
        vecs.push_back(mk(1, 1, 10'h291, 8'h00, 8'h00, 1, 8'h66, 3, 3));
        vecs.push_back(mk(1, 1, 10'h291, 8'h00, 8'h00, 1, 8'h66, 3, 3));
        vecs.push_back(mk(1, 0, 10'h291, 8'h5A, 8'h00, 1, 8'h00, 3, 3));
        vecs.push_back(mk(1, 1, 10'h291, 8'h00, 8'h00, 1, 8'h5A, 3, 3));

        for (int k = 0; k < vecs.size(); k++) begin
            if (vecs[k].is_snoop) do_snoop(vecs[k], k);
            else                  do_req(vecs[k], k);
        end

        // Snoop and allocating write hit the same line in one cycle
        sel = 1'b0; read_operation = 1'b0; address = 10'h055; write_data = 8'h99;
        start = 1'b1; flag_snoop = 1'b1; snoop_address = 10'h055;
        tick();
        start = 1'b0; flag_snoop = 1'b0;
        chk("snpwr hit", {v_hit, v_miss}, 2'b01);
        chk("snpwr snoop_hit", v_snoop_hit, 1);
        chk("snpwr miss_count", v_mc, 5);
        chk("snpwr bus", {v_bus_access, v_wr_op, v_bus_wdata}, {2'b11, 8'h99});
        finish = 1'b1;
        tick();
        finish = 1'b0;
        chk("snpwr done", v_done, 1);
        tick();
        do_req(mk(0, 1, 10'h055, 8'h00, 8'h41, 0, 8'h41, 4, 6), 100);

        // Snoop on the outstanding miss address poisons the fill
        read_operation = 1'b1; address = 10'h010; start = 1'b1;
        tick();
        start = 1'b0;
        chk("poison accept", {v_bus_access, v_miss}, 2'b11);
        chk("poison miss_count", v_mc, 7);
        flag_snoop = 1'b1; snoop_address = 10'h010;
        tick();
        flag_snoop = 1'b0;
        chk("poison snoop_hit", v_snoop_hit, 0);
        chk("poison still busy", v_bus_access, 1);
        finish = 1'b1; bus_rdata = 8'hAB;
        tick();
        finish = 1'b0;
        chk("poison done", v_done, 1);
        chk("poison read_data", v_read_data, 8'hAB);
        tick();
        do_req(mk(0, 1, 10'h010, 8'h00, 8'hCD, 0, 8'hCD, 4, 8), 101);
        do_req(mk(0, 1, 10'h010, 8'h00, 8'h00, 1, 8'hCD, 5, 8), 102);

        // finish while idle is ignored
        finish = 1'b1;
        tick();
        finish = 1'b0;
        chk("idle finish", {v_done, v_busy, v_bus_access}, 0);

        // Reset in the middle of a read miss
        read_operation = 1'b1; address = 10'h048; start = 1'b1;
        tick();
        start = 1'b0;
        chk("rstmid accept", v_bus_access, 1);
        chk("rstmid miss_count", v_mc, 9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid bus_access", {v_bus_access, v_busy}, 0);
        chk("rstmid counts", {v_hc, v_mc}, 0);
        chk("rstmid read_data", v_read_data, 0);
        do_req(mk(0, 1, 10'h010, 8'h00, 8'h12, 0, 8'h12, 0, 1), 103);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
